// File: rtl/scene_sequencer.sv
// Game-flow controller: title -> intro -> overworld rooms -> battle -> game over.
// Every scene change goes through a timed fade-out to black, a room/scene swap at
// full black, and a fade-in back to visible. Key presses are edge-detected so a
// held key fires once. All outputs are registered.
module scene_sequencer #(
  parameter int         NUM_MAPS   = 4,
  parameter int         FADE_STEPS = 8,
  parameter int         FADE_DIV   = 262144,
  parameter logic [7:0] KEY_START  = 8'h28,
  parameter logic [7:0] KEY_NEXT   = 8'h2C,
  parameter logic [7:0] KEY_ACT    = 8'h1D,
  localparam int        MAP_W      = $clog2(NUM_MAPS),
  localparam int        FADE_W     = $clog2(FADE_STEPS + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic              arrived_door,
  input  logic [MAP_W-1:0]  door_dest,
  input  logic              encounter,
  input  logic              battle_done,
  input  logic              battle_lost,
  output logic [3:0]        status,
  output logic [MAP_W-1:0]  map_idx,
  output logic [FADE_W-1:0] fade_level,
  output logic              scene_start
);

  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_INTRO    = 3'd1,
    S_MAP      = 3'd2,
    S_BATTLE   = 3'd3,
    S_GAMEOVER = 3'd4,
    S_FADE_OUT = 3'd5,
    S_FADE_IN  = 3'd6
  } state_t;

  state_t             state, state_n;
  state_t             pend_state, pend_state_n;
  logic [MAP_W-1:0]   pend_map, pend_map_n;
  logic [MAP_W-1:0]   map_idx_n;
  logic [FADE_W-1:0]  fade_n;
  logic [PRE_W-1:0]   prescaler, prescaler_n;
  logic [7:0]         key_q;
  logic [3:0]         status_n;
  logic               scene_start_n;

  logic hit_start, hit_next, hit_act, tick, door_ok;

  // A key "hits" only on the cycle it first appears.
  assign hit_start = (keycode == KEY_START) && (key_q != KEY_START);
  assign hit_next  = (keycode == KEY_NEXT)  && (key_q != KEY_NEXT);
  assign hit_act   = (keycode == KEY_ACT)   && (key_q != KEY_ACT);
  assign tick      = (prescaler == PRE_W'(FADE_DIV - 1));
  // Doors to non-existent rooms or back into the current room do nothing.
  assign door_ok   = (int'(door_dest) < NUM_MAPS) && (door_dest != map_idx);

  // State register and all registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_TITLE;
      pend_state  <= S_TITLE;
      pend_map    <= '0;
      map_idx     <= '0;
      fade_level  <= '0;
      prescaler   <= '0;
      key_q       <= 8'h00;
      status      <= 4'd1;
      scene_start <= 1'b0;
    end else begin
      state       <= state_n;
      pend_state  <= pend_state_n;
      pend_map    <= pend_map_n;
      map_idx     <= map_idx_n;
      fade_level  <= fade_n;
      prescaler   <= prescaler_n;
      key_q       <= keycode;
      status      <= status_n;
      scene_start <= scene_start_n;
    end
  end

  // Next-state logic: scene decisions, fade stepping and the room swap at full black.
  always_comb begin
    state_n      = state;
    pend_state_n = pend_state;
    pend_map_n   = pend_map;
    map_idx_n    = map_idx;
    fade_n       = fade_level;
    prescaler_n  = '0;
    unique case (state)
      S_TITLE: begin
        if (hit_start) begin
          state_n      = S_FADE_OUT;
          pend_state_n = S_INTRO;
        end
      end
      S_INTRO: begin
        if (hit_next) begin
          state_n      = S_FADE_OUT;
          pend_state_n = S_MAP;
          pend_map_n   = '0;
        end
      end
      S_MAP: begin
        // Encounters outrank door use in the same cycle.
        if (encounter) begin
          state_n      = S_FADE_OUT;
          pend_state_n = S_BATTLE;
          pend_map_n   = map_idx;
        end else if (arrived_door && hit_act && door_ok) begin
          state_n      = S_FADE_OUT;
          pend_state_n = S_MAP;
          pend_map_n   = door_dest;
        end
      end
      S_BATTLE: begin
        if (battle_done) begin
          state_n      = S_FADE_OUT;
          pend_state_n = battle_lost ? S_GAMEOVER : S_MAP;
          pend_map_n   = map_idx;
        end
      end
      S_GAMEOVER: begin
        if (hit_start) begin
          state_n      = S_FADE_OUT;
          pend_state_n = S_TITLE;
          pend_map_n   = '0;
        end
      end
      S_FADE_OUT: begin
        prescaler_n = tick ? '0 : prescaler + PRE_W'(1);
        if (tick) begin
          fade_n = fade_level + FADE_W'(1);
          if (fade_level == FADE_W'(FADE_STEPS - 1)) begin
            state_n   = S_FADE_IN;
            map_idx_n = pend_map;
          end
        end
      end
      S_FADE_IN: begin
        prescaler_n = tick ? '0 : prescaler + PRE_W'(1);
        if (tick) begin
          fade_n = fade_level - FADE_W'(1);
          if (fade_level == FADE_W'(1)) begin
            state_n = pend_state;
          end
        end
      end
      default: begin
        state_n = S_TITLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    status_n      = 4'd0;
    scene_start_n = (state == S_FADE_IN) && (state_n != S_FADE_IN);
    unique case (state_n)
      S_TITLE:    status_n = 4'd1;
      S_INTRO:    status_n = 4'd2;
      S_MAP:      status_n = 4'd3;
      S_BATTLE:   status_n = 4'd4;
      S_GAMEOVER: status_n = 4'd5;
      default:    status_n = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer with short fades (FADE_DIV=2, FADE_STEPS=4).
// A second instance built with NUM_MAPS=3 shares all inputs and is used for the
// out-of-range door check.
module tb_scene_sequencer;

  localparam int NUM_MAPS   = 4;
  localparam int FADE_STEPS = 4;
  localparam int FADE_DIV   = 2;
  localparam int HALF       = FADE_STEPS * FADE_DIV;
  localparam int W          = 10;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] keycode;
  logic       arrived_door;
  logic [1:0] door_dest;
  logic       encounter, battle_done, battle_lost;

  logic [3:0] status_a, status_b;
  logic [1:0] map_a, map_b;
  logic [2:0] fade_a, fade_b;
  logic       ss_a, ss_b;

  scene_sequencer #(.NUM_MAPS(NUM_MAPS), .FADE_STEPS(FADE_STEPS), .FADE_DIV(FADE_DIV)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .arrived_door(arrived_door),
    .door_dest(door_dest), .encounter(encounter), .battle_done(battle_done),
    .battle_lost(battle_lost), .status(status_a), .map_idx(map_a),
    .fade_level(fade_a), .scene_start(ss_a)
  );

  scene_sequencer #(.NUM_MAPS(3), .FADE_STEPS(FADE_STEPS), .FADE_DIV(FADE_DIV)) dut3 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .arrived_door(arrived_door),
    .door_dest(door_dest), .encounter(encounter), .battle_done(battle_done),
    .battle_lost(battle_lost), .status(status_b), .map_idx(map_b),
    .fade_level(fade_b), .scene_start(ss_b)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    check_b = 1'b1;
  string tag = "reset";

  typedef struct packed {
    logic [7:0] kc;
    logic       ad;
    logic [1:0] dd;
    logic       enc;
    logic       bd;
    logic       bl;
    logic [3:0] st;
    logic [1:0] mp;
    logic [2:0] fd;
    logic       ss;
  } vec_t;

  vec_t tv[6];

  function automatic logic [W-1:0] pk(input logic [3:0] s, input logic [1:0] m,
                                      input logic [2:0] f, input logic ss);
    return {s, m, f, ss};
  endfunction

  // Expected outputs k edges after the edge that started a fade.
  function automatic logic [W-1:0] fade_exp(input int k, input logic [3:0] st_new,
                                            input logic [1:0] m_old, input logic [1:0] m_new);
    logic [2:0] f;
    if (k <= HALF) f = 3'(k / FADE_DIV);
    else           f = 3'(FADE_STEPS - (k - HALF) / FADE_DIV);
    return pk((k == 2 * HALF) ? st_new : 4'd0, (k >= HALF) ? m_new : m_old, f, k == 2 * HALF);
  endfunction

  task automatic report(input string who, input logic [W-1:0] got, input logic [W-1:0] e);
    $display("FAIL %s [%s]: got st=%0d map=%0d fade=%0d ss=%0d, exp st=%0d map=%0d fade=%0d ss=%0d",
             tag, who, got[9:6], got[5:4], got[3:1], got[0], e[9:6], e[5:4], e[3:1], e[0]);
  endtask

  task automatic compare_pop();
    logic [W-1:0] e;
    logic [W-1:0] got;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    got = {status_a, map_a, fade_a, ss_a};
    if (got !== e) begin
      n_bad++;
      report("maps4", got, e);
    end
    if (check_b) begin
      n_cmp++;
      got = {status_b, map_b, fade_b, ss_b};
      if (got !== e) begin
        n_bad++;
        report("maps3", got, e);
      end
    end
  endtask

  task automatic check_b_only(input logic [W-1:0] e);
    logic [W-1:0] got;
    n_cmp++;
    got = {status_b, map_b, fade_b, ss_b};
    if (got !== e) begin
      n_bad++;
      report("maps3", got, e);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [7:0] kc, input logic ad, input logic [1:0] dd,
                       input logic enc, input logic bd, input logic bl);
    keycode      = kc;
    arrived_door = ad;
    door_dest    = dd;
    encounter    = enc;
    battle_done  = bd;
    battle_lost  = bl;
  endtask

  task automatic cycle(input logic [7:0] kc, input logic ad, input logic [1:0] dd,
                       input logic enc, input logic bd, input logic bl, input logic [W-1:0] e);
    drive(kc, ad, dd, enc, bd, bl);
    exp_q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    compare_pop();
  endtask

  // Full fade; with rnd set all inputs are randomised (they must be ignored),
  // except the final cycle which is left idle so the next scene sees a clean key.
  task automatic run_fade(input logic [3:0] st_new, input logic [1:0] m_old,
                          input logic [1:0] m_new, input bit rnd, input logic [7:0] kc_hold);
    for (int k = 1; k <= 2 * HALF; k++) begin
      if (rnd && k < 2 * HALF)
        drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (rnd)
        drive(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      else
        drive(kc_hold, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(fade_exp(k, st_new, m_old, m_new));
      @(posedge Clk);
      @(negedge Clk);
      compare_pop();
    end
  endtask

  initial begin
    tv[0] = '{kc: 8'h2C, ad: 1'b0, dd: 2'd0, enc: 1'b0, bd: 1'b0, bl: 1'b0, st: 4'd1, mp: 2'd0, fd: 3'd0, ss: 1'b0};
    tv[1] = '{kc: 8'h1D, ad: 1'b1, dd: 2'd2, enc: 1'b0, bd: 1'b0, bl: 1'b0, st: 4'd1, mp: 2'd0, fd: 3'd0, ss: 1'b0};
    tv[2] = '{kc: 8'h00, ad: 1'b0, dd: 2'd0, enc: 1'b1, bd: 1'b0, bl: 1'b0, st: 4'd1, mp: 2'd0, fd: 3'd0, ss: 1'b0};
    tv[3] = '{kc: 8'h00, ad: 1'b0, dd: 2'd0, enc: 1'b0, bd: 1'b1, bl: 1'b1, st: 4'd1, mp: 2'd0, fd: 3'd0, ss: 1'b0};
    tv[4] = '{kc: 8'h00, ad: 1'b0, dd: 2'd0, enc: 1'b0, bd: 1'b0, bl: 1'b0, st: 4'd1, mp: 2'd0, fd: 3'd0, ss: 1'b0};
    tv[5] = '{kc: 8'h28, ad: 1'b0, dd: 2'd0, enc: 1'b0, bd: 1'b0, bl: 1'b0, st: 4'd0, mp: 2'd0, fd: 3'd0, ss: 1'b0};

    drive(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 Reset = 1'b1;
    #1;
    exp_q.push_back(pk(4'd1, 2'd0, 3'd0, 1'b0));
    compare_pop();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // title: only a fresh KEY_START leaves; the last vector starts the fade
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("title_vec%0d", i);
      cycle(tv[i].kc, tv[i].ad, tv[i].dd, tv[i].enc, tv[i].bd, tv[i].bl,
            pk(tv[i].st, tv[i].mp, tv[i].fd, tv[i].ss));
    end
    tag = "title_fade_held";
    run_fade(4'd2, 2'd0, 2'd0, 1'b0, 8'h28);
    tag = "intro_held";
    for (int i = 0; i < 3; i++) cycle(8'h28, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd2, 2'd0, 3'd0, 1'b0));

    // intro -> map 0
    tag = "intro_next";
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd2, 2'd0, 3'd0, 1'b0));
    cycle(8'h2C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    tag = "intro_fade";
    run_fade(4'd3, 2'd0, 2'd0, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));

    // doors: same room ignored, held key ignored, no door ignored, then room 2
    tag = "door_same_room";
    cycle(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    tag = "door_key_held";
    cycle(8'h1D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    tag = "door_release";
    cycle(8'h00, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    tag = "door_not_arrived";
    cycle(8'h1D, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    cycle(8'h00, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    tag = "door_to_2";
    cycle(8'h1D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    run_fade(4'd3, 2'd0, 2'd2, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd2, 3'd0, 1'b0));

    // encounter beats door key in the same cycle
    tag = "enc_vs_door";
    cycle(8'h1D, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, pk(4'd0, 2'd2, 3'd0, 1'b0));
    run_fade(4'd4, 2'd2, 2'd2, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd4, 2'd2, 3'd0, 1'b0));

    // battle: stray inputs ignored, then win (battle_done beats encounter)
    tag = "battle_ignore";
    cycle(8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(4'd4, 2'd2, 3'd0, 1'b0));
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pk(4'd4, 2'd2, 3'd0, 1'b0));
    cycle(8'h28, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd4, 2'd2, 3'd0, 1'b0));
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd4, 2'd2, 3'd0, 1'b0));
    tag = "battle_win";
    cycle(8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(4'd0, 2'd2, 3'd0, 1'b0));
    run_fade(4'd3, 2'd2, 2'd2, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd2, 3'd0, 1'b0));

    // battle loss -> game over -> title with room reset
    tag = "battle_again";
    cycle(8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(4'd0, 2'd2, 3'd0, 1'b0));
    run_fade(4'd4, 2'd2, 2'd2, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd4, 2'd2, 3'd0, 1'b0));
    tag = "battle_lost";
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, pk(4'd0, 2'd2, 3'd0, 1'b0));
    run_fade(4'd5, 2'd2, 2'd2, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd5, 2'd2, 3'd0, 1'b0));
    tag = "gameover";
    cycle(8'h2C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd5, 2'd2, 3'd0, 1'b0));
    cycle(8'h28, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd2, 3'd0, 1'b0));
    run_fade(4'd1, 2'd2, 2'd0, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd1, 2'd0, 3'd0, 1'b0));

    // back to map 0, then door 3: valid with 4 rooms, out of range with 3
    tag = "replay";
    cycle(8'h28, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    run_fade(4'd2, 2'd0, 2'd0, 1'b1, 8'h00);
    cycle(8'h2C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    run_fade(4'd3, 2'd0, 2'd0, 1'b1, 8'h00);
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd0, 3'd0, 1'b0));
    check_b = 1'b0;
    tag = "door_out_of_range";
    cycle(8'h1D, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    check_b_only(pk(4'd3, 2'd0, 3'd0, 1'b0));
    run_fade(4'd3, 2'd0, 2'd3, 1'b0, 8'h00);
    check_b_only(pk(4'd3, 2'd0, 3'd0, 1'b0));
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd3, 2'd3, 3'd0, 1'b0));

    // asynchronous reset while fading in at level 3
    tag = "reset_mid_fade";
    cycle(8'h1D, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd3, 3'd0, 1'b0));
    for (int k = 1; k <= HALF + 2; k++) begin
      cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, fade_exp(k, 4'd3, 2'd3, 2'd1));
    end
    check_b = 1'b1;
    #2 Reset = 1'b1;
    #1;
    tag = "reset_async";
    exp_q.push_back(pk(4'd1, 2'd0, 3'd0, 1'b0));
    compare_pop();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    tag = "after_reset";
    cycle(8'h28, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));
    cycle(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(4'd0, 2'd0, 3'd0, 1'b0));

    // final report
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expectations never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
